// File: rtl/mfp_reset_sequencer.sv
// Multi-channel reset sequencer: synchronised board-reset release, a programmable hold,
// staggered channel release, then per-channel soft-reset pulses and full restarts.

module mfp_rst_chan #(
    parameter int PULSE_W = 16
) (
    input  logic HCLK,
    input  logic HRESETn,
    input  logic soft_req,
    input  logic in_done,
    input  logic done_entry,
    input  logic seq_clr,
    input  logic release_set,
    output logic chan_rst_n,
    output logic active_nxt
);
    localparam int PW = $clog2(PULSE_W + 1);

    logic          prev, hit, pend, chan;
    logic [PW-1:0] cnt;
    logic          prev_d, hit_d, pend_d, chan_d;
    logic [PW-1:0] cnt_d;
    logic          rise;

    assign rise = soft_req & ~prev;

    always_comb begin
        prev_d = soft_req;
        hit_d  = hit;
        pend_d = pend;
        cnt_d  = cnt;
        chan_d = chan;
        if (seq_clr) begin
            hit_d  = 1'b0;
            pend_d = 1'b0;
            cnt_d  = '0;
            chan_d = 1'b0;
        end else begin
            // Edges seen before DONE are parked and replayed on the DONE entry edge.
            if (done_entry) begin
                hit_d  = pend | rise;
                pend_d = 1'b0;
            end else if (in_done) begin
                hit_d = rise;
            end else begin
                pend_d = pend | rise;
                hit_d  = 1'b0;
            end
            if (hit) begin
                chan_d = 1'b0;
                cnt_d  = PW'(PULSE_W);
            end else if (cnt != '0) begin
                cnt_d = cnt - PW'(1);
                if (cnt == PW'(1))
                    chan_d = 1'b1;
            end else if (release_set) begin
                chan_d = 1'b1;
            end
        end
    end

    always_ff @(posedge HCLK or negedge HRESETn) begin
        if (!HRESETn) begin
            prev <= 1'b0;
            hit  <= 1'b0;
            pend <= 1'b0;
            cnt  <= '0;
            chan <= 1'b0;
        end else begin
            prev <= prev_d;
            hit  <= hit_d;
            pend <= pend_d;
            cnt  <= cnt_d;
            chan <= chan_d;
        end
    end

    assign chan_rst_n = chan;
    assign active_nxt = hit_d | (cnt_d != '0);
endmodule

module mfp_reset_sequencer #(
    parameter int N_CH        = 3,
    parameter int PULSE_W     = 16,
    parameter int STAGGER     = 4,
    parameter int SYNC_STAGES = 2
) (
    input  logic            HCLK,
    input  logic            HRESETn,
    input  logic            seq_req,
    input  logic [N_CH-1:0] soft_req,
    input  logic [N_CH-1:0] ext_rst_n,
    output logic [N_CH-1:0] rst_n_out,
    output logic            busy,
    output logic            done
);
    localparam logic [1:0] SYNC    = 2'd0;
    localparam logic [1:0] HOLD    = 2'd1;
    localparam logic [1:0] RELEASE = 2'd2;
    localparam logic [1:0] DONE    = 2'd3;

    localparam int CMAX       = (PULSE_W > STAGGER) ? PULSE_W : STAGGER;
    localparam int CW         = $clog2(CMAX + 1);
    localparam int IW         = (N_CH > 1) ? $clog2(N_CH) : 1;
    localparam int PULSE_LAST = PULSE_W - 1;
    localparam int STG_LAST   = (STAGGER > 0) ? STAGGER - 1 : 0;
    localparam bit ALL_AT_ONCE = (N_CH == 1) || (STAGGER == 0);

    logic [1:0]             state, state_d;
    logic [CW-1:0]          cnt, cnt_d;
    logic [IW-1:0]          idx, idx_d;
    logic                   done_d;
    logic                   done_entry, seq_clr;
    logic [N_CH-1:0]        rel, chan_q, act_d;
    logic [SYNC_STAGES-1:0] sync_q;

    always_ff @(posedge HCLK or negedge HRESETn) begin
        if (!HRESETn) sync_q <= '0;
        else          sync_q <= {sync_q[SYNC_STAGES-2:0], 1'b1};
    end

    assign seq_clr = seq_req && (state != SYNC);

    always_comb begin
        state_d    = state;
        cnt_d      = cnt;
        idx_d      = idx;
        done_d     = done;
        rel        = '0;
        done_entry = 1'b0;
        case (state)
            SYNC: begin
                if (sync_q[SYNC_STAGES-1]) begin
                    state_d = HOLD;
                    cnt_d   = '0;
                end
            end
            HOLD: begin
                if (cnt == CW'(PULSE_LAST)) begin
                    if (ALL_AT_ONCE) begin
                        rel        = '1;
                        state_d    = DONE;
                        done_d     = 1'b1;
                        done_entry = 1'b1;
                    end else begin
                        rel[0]  = 1'b1;
                        state_d = RELEASE;
                        idx_d   = IW'(1);
                        cnt_d   = '0;
                    end
                end else begin
                    cnt_d = cnt + CW'(1);
                end
            end
            RELEASE: begin
                if (cnt == CW'(STG_LAST)) begin
                    for (int i = 0; i < N_CH; i++)
                        if (idx == IW'(i)) rel[i] = 1'b1;
                    cnt_d = '0;
                    idx_d = idx + IW'(1);
                    if (idx == IW'(N_CH - 1)) begin
                        state_d    = DONE;
                        done_d     = 1'b1;
                        done_entry = 1'b1;
                    end
                end else begin
                    cnt_d = cnt + CW'(1);
                end
            end
            default: ;
        endcase
        // A restart overrides whatever the state machine decided this cycle.
        if (seq_clr) begin
            state_d    = HOLD;
            cnt_d      = '0;
            idx_d      = '0;
            done_d     = 1'b0;
            rel        = '0;
            done_entry = 1'b0;
        end
    end

    always_ff @(posedge HCLK or negedge HRESETn) begin
        if (!HRESETn) begin
            state <= SYNC;
            cnt   <= '0;
            idx   <= '0;
            done  <= 1'b0;
            busy  <= 1'b1;
        end else begin
            state <= state_d;
            cnt   <= cnt_d;
            idx   <= idx_d;
            done  <= done_d;
            busy  <= !((state_d == DONE) && (act_d == '0));
        end
    end

    for (genvar g = 0; g < N_CH; g++) begin : g_ch
        mfp_rst_chan #(.PULSE_W(PULSE_W)) u_ch (
            .HCLK        (HCLK),
            .HRESETn     (HRESETn),
            .soft_req    (soft_req[g]),
            .in_done     (state == DONE),
            .done_entry  (done_entry),
            .seq_clr     (seq_clr),
            .release_set (rel[g]),
            .chan_rst_n  (chan_q[g]),
            .active_nxt  (act_d[g])
        );
    end

    // External resets bypass the clock domain so a probe TRST acts immediately.
    assign rst_n_out = chan_q & ext_rst_n;
endmodule

// File: tb/tb_mfp_reset_sequencer.sv
// Directed bench: default sequencer plus a 4-channel zero-stagger instance.

module tb_mfp_reset_sequencer;
    logic       HCLK = 1'b0;
    logic       HRESETn = 1'b0;
    logic       seq_req = 1'b0;
    logic [2:0] soft_req = '0;
    logic [2:0] ext_rst_n = '1;
    logic [2:0] rst_n_out;
    logic       busy, done;

    logic       seq_req2 = 1'b0;
    logic [3:0] soft_req2 = '0;
    logic [3:0] ext_rst_n2 = '1;
    logic [3:0] rst_n_out2;
    logic       busy2, done2;

    int n_chk = 0;
    int n_pass = 0;
    int e = 0;
    int k = 0;

    always #5 HCLK = ~HCLK;

    mfp_reset_sequencer dut (
        .HCLK(HCLK), .HRESETn(HRESETn), .seq_req(seq_req), .soft_req(soft_req),
        .ext_rst_n(ext_rst_n), .rst_n_out(rst_n_out), .busy(busy), .done(done)
    );

    mfp_reset_sequencer #(.N_CH(4), .STAGGER(0)) dut2 (
        .HCLK(HCLK), .HRESETn(HRESETn), .seq_req(seq_req2), .soft_req(soft_req2),
        .ext_rst_n(ext_rst_n2), .rst_n_out(rst_n_out2), .busy(busy2), .done(done2)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s @edge %0d: got %0h want %0h", tag, e, got, exp);
    endtask

    task automatic step();
        @(posedge HCLK);
        #1;
        e++;
    endtask

    function automatic logic [2:0] release_pat(input int t);
        return {t >= 27, t >= 23, t >= 19};
    endfunction

    initial begin
        // reset state
        repeat (3) @(posedge HCLK);
        #1;
        chk("rst_out", 32'(rst_n_out), 32'h0);
        chk("rst_done", 32'(done), 32'h0);
        chk("rst_busy", 32'(busy), 32'h1);
        chk("rst_out2", 32'(rst_n_out2), 32'h0);

        // power-on timeline, both instances
        @(negedge HCLK);
        HRESETn = 1'b1;
        e = 0;
        repeat (30) begin
            step();
            chk("tl_out", 32'(rst_n_out), 32'(release_pat(e)));
            chk("tl_done", 32'(done), 32'(e >= 27));
            chk("tl_busy", 32'(busy), 32'(e < 27));
            chk("tl_out2", 32'(rst_n_out2), (e >= 19) ? 32'hf : 32'h0);
            chk("tl_done2", 32'(done2), 32'(e >= 19));
        end

        // single soft pulse on channel 1
        soft_req[1] = 1'b1;
        step();
        k = e;
        chk("sp_k", 32'(rst_n_out), 32'h7);
        for (int i = 1; i <= 17; i++) begin
            if (i == 2) soft_req[1] = 1'b0;
            step();
            chk("sp_out", 32'(rst_n_out), (i <= 16) ? 32'h5 : 32'h7);
            if (i == 5) chk("sp_busy", 32'(busy), 32'h1);
        end
        chk("sp_idle", 32'(busy), 32'h0);

        // extended soft pulse: second rising edge at k+8
        soft_req[1] = 1'b1;
        step();
        k = e;
        for (int i = 1; i <= 25; i++) begin
            if (i == 4) soft_req[1] = 1'b0;
            if (i == 8) soft_req[1] = 1'b1;
            step();
            chk("ext_pulse", 32'(rst_n_out), (i <= 24) ? 32'h5 : 32'h7);
        end
        soft_req[1] = 1'b0;
        step();

        // seq_req beats a simultaneous soft edge
        seq_req = 1'b1;
        soft_req[0] = 1'b1;
        step();
        seq_req = 1'b0;
        chk("seq_out", 32'(rst_n_out), 32'h0);
        chk("seq_done", 32'(done), 32'h0);
        chk("seq_busy", 32'(busy), 32'h1);
        for (int i = 1; i <= 30; i++) begin
            step();
            chk("seq_tl", 32'(rst_n_out), 32'({i >= 24, i >= 20, i >= 16}));
            chk("seq_tl_done", 32'(done), 32'(i >= 24));
        end
        soft_req[0] = 1'b0;
        step();

        // asynchronous HRESETn mid-RELEASE
        seq_req = 1'b1;
        step();
        seq_req = 1'b0;
        repeat (18) step();
        chk("mid_rel", 32'(rst_n_out), 32'h1);
        #2 HRESETn = 1'b0;
        #1;
        chk("arst_out", 32'(rst_n_out), 32'h0);
        chk("arst_done", 32'(done), 32'h0);
        chk("arst_busy", 32'(busy), 32'h1);
        chk("arst_out2", 32'(rst_n_out2), 32'h0);
        @(negedge HCLK);
        @(negedge HCLK);
        HRESETn = 1'b1;
        e = 0;

        // replayed timeline with a soft edge on channel 2 during HOLD
        for (int i = 1; i <= 45; i++) begin
            if (i == 6) soft_req[2] = 1'b1;
            if (i == 10) soft_req[2] = 1'b0;
            step();
            chk("pend_out", 32'(rst_n_out),
                32'({(e >= 27) && !(e >= 28 && e <= 43), e >= 23, e >= 19}));
            chk("pend_done", 32'(done), 32'(e >= 27));
            if (e == 27) chk("pend_busy27", 32'(busy), 32'h1);
            if (e == 44) chk("pend_busy44", 32'(busy), 32'h0);
        end

        // ext_rst_n gates asynchronously and leaves the FSM alone
        ext_rst_n[0] = 1'b0;
        #1;
        chk("ext_out", 32'(rst_n_out), 32'h6);
        chk("ext_done", 32'(done), 32'h1);
        step();
        chk("ext_hold", 32'(rst_n_out), 32'h6);
        chk("ext_busy", 32'(busy), 32'h0);
        ext_rst_n[0] = 1'b1;
        #1;
        chk("ext_rel", 32'(rst_n_out), 32'h7);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
